// File: rtl/unidade_pc.sv
// rtl/unidade_pc.sv - registered program counter with next-PC selection and return-address stack
//
// Purpose: holds the PC of the iZero MIPS datapath and computes the next PC from
// addOp/opcode, the ALU flags and the jump/branch targets. JAL pushes pc+1 onto a
// circular return-address stack and RET pops it.
//
// Ports:
//   clock          in   rising-edge clock
//   reset          in   asynchronous active-low reset
//   habilita       in   1 = commit pcProximo and the stack update on this edge
//   addOp          in   00 hold, 01 increment, 10 opcode decode, 11 jump to salto
//   opcode         in   instruction opcode
//   menor/maior/igual in ALU flags
//   salto          in   unconditional jump target
//   saltoJR        in   register jump target (JR, RET on empty stack)
//   desvio         in   branch target/offset, JAL target
//   limpa_erros    in   clears the sticky error flags on the next edge
//   pc             out  current PC
//   pcProximo      out  next PC (combinational)
//   ras_vazia      out  stack empty
//   ras_cheia      out  stack full
//   erro_overflow  out  sticky: push while full
//   erro_underflow out  sticky: RET while empty
module unidade_pc #(
  parameter int                 ADDR_W     = 26,
  parameter int                 DESVIO_W   = 16,
  parameter int                 DESVIO_REL = 0,
  parameter int                 RAS_DEPTH  = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                habilita,
  input  logic [1:0]          addOp,
  input  logic [5:0]          opcode,
  input  logic                menor,
  input  logic                maior,
  input  logic                igual,
  input  logic [ADDR_W-1:0]   salto,
  input  logic [ADDR_W-1:0]   saltoJR,
  input  logic [DESVIO_W-1:0] desvio,
  input  logic                limpa_erros,
  output logic [ADDR_W-1:0]   pc,
  output logic [ADDR_W-1:0]   pcProximo,
  output logic                ras_vazia,
  output logic                ras_cheia,
  output logic                erro_overflow,
  output logic                erro_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  localparam logic [5:0] OP_BEQ  = 6'b011001;
  localparam logic [5:0] OP_BNE  = 6'b011010;
  localparam logic [5:0] OP_BLT  = 6'b011011;
  localparam logic [5:0] OP_BLET = 6'b011100;
  localparam logic [5:0] OP_BGT  = 6'b011101;
  localparam logic [5:0] OP_BGET = 6'b011110;
  localparam logic [5:0] OP_JAL  = 6'b100000;
  localparam logic [5:0] OP_JR   = 6'b100001;
  localparam logic [5:0] OP_RET  = 6'b100010;

  logic [ADDR_W-1:0] pilha [RAS_DEPTH];
  logic [PTR_W-1:0]  topo;
  logic [PTR_W-1:0]  topo_mais;
  logic [CNT_W-1:0]  conta;

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] desvio_abs;
  logic [ADDR_W-1:0] desvio_sext;
  logic [ADDR_W-1:0] alvo_branch;
  logic              cond;
  logic              push;
  logic              pop;
  logic              set_ovf;
  logic              set_unf;

  assign pc_inc      = pc + ADDR_W'(1);
  assign desvio_abs  = ADDR_W'(desvio);
  assign desvio_sext = ADDR_W'($signed(desvio));
  // JAL always uses the absolute form; only conditional branches honour DESVIO_REL.
  assign alvo_branch = (DESVIO_REL != 0) ? (pc_inc + desvio_sext) : desvio_abs;
  // Pointer wraps naturally because RAS_DEPTH is a power of two.
  assign topo_mais   = topo + PTR_W'(1);

  assign ras_vazia = (conta == '0);
  assign ras_cheia = (conta == CNT_W'(RAS_DEPTH));

  always_comb begin
    cond = 1'b0;
    unique case (opcode)
      OP_BEQ:  cond = igual;
      OP_BNE:  cond = !igual;
      OP_BLT:  cond = menor;
      OP_BLET: cond = menor | igual;
      OP_BGT:  cond = maior;
      OP_BGET: cond = maior | igual;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    pcProximo = pc;
    push      = 1'b0;
    pop       = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    case (addOp)
      2'b00: pcProximo = pc;
      2'b01: pcProximo = pc_inc;
      2'b11: pcProximo = salto;
      default: begin
        case (opcode)
          OP_JAL: begin
            pcProximo = desvio_abs;
            push      = 1'b1;
            set_ovf   = ras_cheia;
          end
          OP_JR: pcProximo = saltoJR;
          OP_RET: begin
            if (ras_vazia) begin
              pcProximo = saltoJR;
              set_unf   = 1'b1;
            end else begin
              pcProximo = pilha[topo];
              pop       = 1'b1;
            end
          end
          OP_BEQ, OP_BNE, OP_BLT, OP_BLET, OP_BGT, OP_BGET:
            pcProximo = cond ? alvo_branch : pc_inc;
          default: pcProximo = pc_inc;
        endcase
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc    <= RESET_PC;
      topo  <= '0;
      conta <= '0;
    end else if (habilita) begin
      pc <= pcProximo;
      if (push) begin
        topo <= topo_mais;
        // When full the oldest entry is overwritten, so the count saturates.
        if (!ras_cheia) conta <= conta + CNT_W'(1);
      end else if (pop) begin
        topo  <= topo - PTR_W'(1);
        conta <= conta - CNT_W'(1);
      end
    end
  end

  // Stack contents need no reset: an entry is only read after it was written.
  always_ff @(posedge clock) begin
    if (habilita && push) pilha[topo_mais] <= pc_inc;
  end

  // Clear works regardless of habilita; a simultaneous set takes priority.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      erro_overflow  <= 1'b0;
      erro_underflow <= 1'b0;
    end else begin
      erro_overflow  <= (habilita & set_ovf) | (erro_overflow  & ~limpa_erros);
      erro_underflow <= (habilita & set_unf) | (erro_underflow & ~limpa_erros);
    end
  end

endmodule
